// File: rtl/bp_cfg_link_loader_pkg.sv
// Shared cfg-link definitions: register offsets, loader sequence states and the write record.
package bp_cfg_link_loader_pkg;

    localparam int unsigned CFG_ADDR_W = 16;
    localparam int unsigned CFG_DATA_W = 32;

    // Offsets are relative to the cfg base that the network prepends.
    localparam logic [CFG_ADDR_W-1:0] CFG_REG_FREEZE     = 16'h0002;
    localparam logic [CFG_ADDR_W-1:0] CFG_REG_CORE_ID    = 16'h0003;
    localparam logic [CFG_ADDR_W-1:0] CFG_REG_NPC        = 16'h0040;
    localparam logic [CFG_ADDR_W-1:0] CFG_REG_CCE_ID     = 16'h0080;
    localparam logic [CFG_ADDR_W-1:0] CFG_REG_CCE_MODE   = 16'h0081;
    localparam logic [CFG_ADDR_W-1:0] CFG_REG_UCODE_BASE = 16'h8000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FREEZE,
        S_CORE_ID,
        S_NPC,
        S_CCE_ID,
        S_CCE_MODE,
        S_UCODE_RD,
        S_UCODE_WR,
        S_UNFREEZE,
        S_DONE
    } bp_cfg_loader_state_e;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
    } bp_cfg_write_s;

endpackage

// File: rtl/bp_cfg_link_loader.sv
// Cfg-link initiator: freezes a tile, programs ids/npc/mode, streams CCE microcode, unfreezes.
module bp_cfg_link_loader
    import bp_cfg_link_loader_pkg::*;
#(
    parameter int unsigned cfg_addr_width_p   = 16,
    parameter int unsigned cfg_data_width_p   = 32,
    parameter int unsigned core_id_width_p    = 8,
    parameter int unsigned ucode_els_p        = 256,
    parameter int unsigned ucode_addr_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          start_i,
    input  logic                          skip_ucode_i,
    input  logic [core_id_width_p-1:0]    core_id_i,
    input  logic [cfg_data_width_p-1:0]   npc_i,
    input  logic                          cce_mode_i,
    output logic [ucode_addr_width_p-1:0] rom_addr_o,
    output logic                          rom_v_o,
    input  logic [cfg_data_width_p-1:0]   rom_data_i,
    output logic                          cfg_v_o,
    output logic [cfg_addr_width_p-1:0]   cfg_addr_o,
    output logic [cfg_data_width_p-1:0]   cfg_data_o,
    input  logic                          cfg_ready_i,
    output logic                          busy_o,
    output logic                          done_o
);

    bp_cfg_loader_state_e state, state_n;

    logic [core_id_width_p-1:0]    core_id_r;
    logic [cfg_data_width_p-1:0]   npc_r;
    logic [cfg_data_width_p-1:0]   hold_r;
    logic                          mode_r;
    logic                          skip_r;
    logic                          done_r;
    logic                          wr_first_r;
    logic [ucode_addr_width_p-1:0] idx;

    bp_cfg_write_s wr;
    logic          start_ok;
    logic          accept;
    logic          last_idx;

    assign start_ok = start_i && ((state == S_IDLE) || (state == S_DONE));
    assign accept   = cfg_v_o && cfg_ready_i;
    assign last_idx = (idx == ucode_addr_width_p'(ucode_els_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= S_IDLE;
        else            state <= state_n;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            core_id_r  <= '0;
            npc_r      <= '0;
            hold_r     <= '0;
            mode_r     <= 1'b0;
            skip_r     <= 1'b0;
            done_r     <= 1'b0;
            wr_first_r <= 1'b0;
            idx        <= '0;
        end else begin
            if (start_ok) begin
                core_id_r <= core_id_i;
                npc_r     <= npc_i;
                mode_r    <= cce_mode_i;
                skip_r    <= skip_ucode_i;
                idx       <= '0;
                done_r    <= 1'b0;
            end
            if ((state == S_UNFREEZE) && accept) done_r <= 1'b1;
            if ((state == S_UCODE_WR) && accept && !last_idx) idx <= idx + 1'b1;
            // ROM data is only valid in the first UCODE_WR cycle; hold it for any stall.
            wr_first_r <= (state == S_UCODE_RD);
            if (wr_first_r) hold_r <= rom_data_i;
        end
    end

    always_comb begin
        state_n    = state;
        wr         = '0;
        cfg_v_o    = 1'b0;
        rom_v_o    = 1'b0;
        rom_addr_o = '0;
        unique case (state)
            S_IDLE, S_DONE: if (start_ok) state_n = S_FREEZE;
            S_FREEZE: begin
                cfg_v_o = 1'b1;
                wr      = '{addr: CFG_REG_FREEZE, data: CFG_DATA_W'(1)};
                if (cfg_ready_i) state_n = S_CORE_ID;
            end
            S_CORE_ID: begin
                cfg_v_o = 1'b1;
                wr      = '{addr: CFG_REG_CORE_ID, data: CFG_DATA_W'(core_id_r)};
                if (cfg_ready_i) state_n = S_NPC;
            end
            S_NPC: begin
                cfg_v_o = 1'b1;
                wr      = '{addr: CFG_REG_NPC, data: CFG_DATA_W'(npc_r)};
                if (cfg_ready_i) state_n = S_CCE_ID;
            end
            S_CCE_ID: begin
                cfg_v_o = 1'b1;
                wr      = '{addr: CFG_REG_CCE_ID, data: CFG_DATA_W'(core_id_r)};
                if (cfg_ready_i) state_n = S_CCE_MODE;
            end
            S_CCE_MODE: begin
                cfg_v_o = 1'b1;
                wr      = '{addr: CFG_REG_CCE_MODE, data: CFG_DATA_W'(mode_r)};
                if (cfg_ready_i) state_n = skip_r ? S_UNFREEZE : S_UCODE_RD;
            end
            S_UCODE_RD: begin
                rom_v_o    = 1'b1;
                rom_addr_o = idx;
                state_n    = S_UCODE_WR;
            end
            S_UCODE_WR: begin
                cfg_v_o = 1'b1;
                wr.addr = CFG_REG_UCODE_BASE + CFG_ADDR_W'(idx);
                wr.data = CFG_DATA_W'(wr_first_r ? rom_data_i : hold_r);
                if (cfg_ready_i) state_n = last_idx ? S_UNFREEZE : S_UCODE_RD;
            end
            S_UNFREEZE: begin
                cfg_v_o = 1'b1;
                wr      = '{addr: CFG_REG_FREEZE, data: '0};
                if (cfg_ready_i) state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign cfg_addr_o = cfg_addr_width_p'(wr.addr);
    assign cfg_data_o = cfg_data_width_p'(wr.data);
    assign busy_o     = (state != S_IDLE) && (state != S_DONE);
    assign done_o     = done_r;

endmodule

// File: tb/tb_bp_cfg_link_loader.sv
// Directed bench for bp_cfg_link_loader with a 4-entry microcode ROM model.
module tb_bp_cfg_link_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        skip = 1'b0;
    logic        mode = 1'b0;
    logic        ready = 1'b1;
    logic [7:0]  core_id = '0;
    logic [31:0] npc = '0;
    logic [1:0]  rom_addr;
    logic        rom_v;
    logic [31:0] rom_data;
    logic        cfg_v;
    logic [15:0] cfg_addr;
    logic [31:0] cfg_data;
    logic        busy;
    logic        done;

    int unsigned n_checks = 0;
    int unsigned n_fails = 0;
    int          cyc = 0;
    int          lat;

    logic [15:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          rom_cyc[$];
    int          uc_cyc[$];

    logic        pend = 1'b0;
    logic [15:0] pa;
    logic [31:0] pd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Synchronous ROM: ROM[i] = 'hA0+i, garbage when not read the cycle before.
    always @(posedge clk) rom_data <= rom_v ? (32'hA0 + 32'(rom_addr)) : 32'hDEAD_BEEF;

    bp_cfg_link_loader #(
        .cfg_addr_width_p  (16),
        .cfg_data_width_p  (32),
        .core_id_width_p   (8),
        .ucode_els_p       (4),
        .ucode_addr_width_p(2)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .start_i     (start),
        .skip_ucode_i(skip),
        .core_id_i   (core_id),
        .npc_i       (npc),
        .cce_mode_i  (mode),
        .rom_addr_o  (rom_addr),
        .rom_v_o     (rom_v),
        .rom_data_i  (rom_data),
        .cfg_v_o     (cfg_v),
        .cfg_addr_o  (cfg_addr),
        .cfg_data_o  (cfg_data),
        .cfg_ready_i (ready),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record accepted writes and enforce the valid/stable handshake.
    always @(negedge clk) begin
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check_eq("valid_held", 32'(cfg_v), 32'd1);
                check_eq("addr_stable", 32'(cfg_addr), 32'(pa));
                check_eq("data_stable", cfg_data, pd);
            end
            check_eq("busy_done_excl", 32'(busy & done), 32'd0);
            if (rom_v) rom_cyc.push_back(cyc);
            if (cfg_v && ready) begin
                got_addr.push_back(cfg_addr);
                got_data.push_back(cfg_data);
                if (cfg_addr[15]) uc_cyc.push_back(cyc);
            end
            pend = cfg_v && !ready;
            pa   = cfg_addr;
            pd   = cfg_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [15:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic exp_build(input logic [7:0] c, input logic [31:0] n, input logic m, input logic s);
        exp_addr.delete();
        exp_data.delete();
        exp_push(16'h0002, 32'h1);
        exp_push(16'h0003, {24'h0, c});
        exp_push(16'h0040, n);
        exp_push(16'h0080, {24'h0, c});
        exp_push(16'h0081, {31'h0, m});
        if (!s) begin
            exp_push(16'h8000, 32'hA0);
            exp_push(16'h8001, 32'hA1);
            exp_push(16'h8002, 32'hA2);
            exp_push(16'h8003, 32'hA3);
        end
        exp_push(16'h0002, 32'h0);
    endtask

    task automatic compare_writes(input string tag);
        check_eq({tag, "_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
            check_eq($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
    endtask

    task automatic run_seq(input logic s, input logic [7:0] c, input logic [31:0] n, input logic m,
                           input bit bp, input int mid_start, output int latency);
        int st;
        int k;
        bit fired;
        got_addr.delete();
        got_data.delete();
        rom_cyc.delete();
        uc_cyc.delete();
        skip = s; core_id = c; npc = n; mode = m; ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        st = cyc;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("done_clr_after_start", 32'(done), 32'd0);
        check_eq("valid_after_start", 32'(cfg_v), 32'd1);
        k = 0;
        fired = 1'b0;
        while (!done && k < 2000) begin
            if (bp) ready = 1'($urandom_range(0, 1));
            if (mid_start > 0 && !fired && rom_cyc.size() >= mid_start) begin
                start = 1'b1;
                core_id = 8'h99;
                npc = 32'h0BAD_0BAD;
                skip = 1'b1;
                fired = 1'b1;
            end
            tick();
            start = 1'b0;
            k++;
        end
        ready = 1'b1;
        check_eq("done_reached", 32'(done), 32'd1);
        latency = cyc - st + 1;
    endtask

    initial begin
        int k;
        // Reset state
        repeat (3) tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_cfg_v", 32'(cfg_v), 32'd0);
        check_eq("rst_rom_v", 32'(rom_v), 32'd0);
        check_eq("rst_cfg_addr", 32'(cfg_addr), 32'd0);
        check_eq("rst_cfg_data", cfg_data, 32'd0);
        reset_n = 1'b1;
        tick();

        // Skip-ucode run, no backpressure
        run_seq(1'b1, 8'h03, 32'h8000_0000, 1'b1, 1'b0, 0, lat);
        exp_build(8'h03, 32'h8000_0000, 1'b1, 1'b1);
        compare_writes("skip");
        check_eq("skip_latency", 32'(lat), 32'd7);
        check_eq("skip_no_rom", 32'(rom_cyc.size()), 32'd0);
        check_eq("skip_busy_end", 32'(busy), 32'd0);

        // Full run with microcode, no backpressure
        run_seq(1'b0, 8'h05, 32'h0000_1234, 1'b0, 1'b0, 0, lat);
        exp_build(8'h05, 32'h0000_1234, 1'b0, 1'b0);
        compare_writes("ucode");
        check_eq("ucode_latency", 32'(lat), 32'd15);
        check_eq("ucode_rom_reads", 32'(rom_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < uc_cyc.size() && i < rom_cyc.size(); i++)
            check_eq($sformatf("ucode_wr_after_rd%0d", i), 32'(uc_cyc[i] - rom_cyc[i]), 32'd1);

        // Same run under random backpressure
        run_seq(1'b0, 8'h05, 32'h0000_1234, 1'b0, 1'b1, 0, lat);
        compare_writes("bp");

        // start pulsed mid-ucode must be ignored
        run_seq(1'b0, 8'h05, 32'h0000_1234, 1'b0, 1'b0, 2, lat);
        compare_writes("mid_start");
        check_eq("mid_start_latency", 32'(lat), 32'd15);

        // Restart from DONE repeats the sequence
        run_seq(1'b0, 8'h05, 32'h0000_1234, 1'b0, 1'b0, 0, lat);
        compare_writes("restart");

        // Reset while a ucode write is stalled
        skip = 1'b0; core_id = 8'h01; npc = '0; mode = 1'b1; ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!rom_v && k < 100) begin
            tick();
            k++;
        end
        check_eq("reach_ucode_rd", 32'(rom_v), 32'd1);
        ready = 1'b0;
        tick();
        check_eq("ucode_wr_pending", 32'(cfg_v), 32'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort_cfg_v", 32'(cfg_v), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        ready = 1'b1;
        tick();
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_done", 32'(done), 32'd0);
        check_eq("post_rst_cfg_v", 32'(cfg_v), 32'd0);

        // Zero-extension of wide id and zero mode
        run_seq(1'b1, 8'hFF, 32'hCAFE_F00D, 1'b0, 1'b0, 0, lat);
        exp_build(8'hFF, 32'hCAFE_F00D, 1'b0, 1'b1);
        compare_writes("zext");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
